led_pwm_bank: RTL and testbench

- Parametrised LED/RGB output stage that replaces direct inverted wiring of processor LED bits.
- Drives NUM_CH PWM channels from a shared prescaler and PWM counter.
- Processor writes duty and control words over a simple register port; duty values are double-buffered so updates take effect only at a period boundary.
- Sits between the datapath store path and the board LED/RGB pins.

---
 rtl/led_pwm_bank.sv | 116 +++++++++++
 tb/tb_led_pwm_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_bank.sv
// NUM_CH-channel PWM LED driver: shared prescaler and period counter, double-buffered
// duty registers reloaded at each period wrap, and a small register port with registered readback.
module led_pwm_bank #(
  parameter int NUM_CH        = 4,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 8,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [3:0]        rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic [NUM_CH-1:0] pwm_out_o,
  output logic              period_tick_o
);

  localparam int              DW        = PWM_BITS + 1;
  localparam logic            INV       = (ACTIVE_LOW != 0);
  localparam logic [3:0]      CTRL_ADDR = 4'(NUM_CH);
  localparam logic [NUM_CH-1:0] IDLE_LVL = {NUM_CH{INV}};

  logic [DW-1:0]            shadow_q [NUM_CH];
  logic [DW-1:0]            shadow_d [NUM_CH];
  logic [DW-1:0]            active_q [NUM_CH];
  logic [DW-1:0]            active_d [NUM_CH];
  logic                     enable_q, enable_d;
  logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
  logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0]        pwm_out_q, pwm_out_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic [NUM_CH-1:0]        on_w;
  logic                     tick;
  logic                     wrap;
  logic                     ctrl_wr;

  assign ctrl_wr = wr_en_i && (wr_addr_i == CTRL_ADDR);
  assign tick    = enable_q && (pre_cnt_q == prescale_q);
  assign wrap    = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});

  // Compare on DW bits so a duty of 2^PWM_BITS or more is permanently on.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
    assign on_w[gi] = enable_q && ({1'b0, pwm_cnt_q} < active_q[gi]);
  end

  always_comb begin
    enable_d   = enable_q;
    prescale_d = prescale_q;
    if (ctrl_wr) begin
      enable_d   = wr_data_i[0];
      prescale_d = wr_data_i[PRESCALE_BITS:1];
    end

    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_en_i && (wr_addr_i == 4'(i))) shadow_d[i] = wr_data_i[PWM_BITS:0];
      // Reload uses the pre-write shadow, so a write landing on the wrap waits a period.
      if (!enable_q || wrap) active_d[i] = shadow_q[i];
    end

    pre_cnt_d = '0;
    pwm_cnt_d = '0;
    if (enable_q) begin
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
      end
    end

    // Disabling forces the pins inactive at the same edge that clears enable.
    pwm_out_d = (enable_d ? on_w : '0) ^ IDLE_LVL;

    rd_data_d = '0;
    if (rd_addr_i == CTRL_ADDR) rd_data_d = 32'({prescale_q, enable_q});
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr_i == 4'(i)) rd_data_d = 32'(shadow_q[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      enable_q   <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      pwm_out_q  <= IDLE_LVL;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      enable_q   <= enable_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_out_q  <= pwm_out_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign pwm_out_o     = pwm_out_q;
  assign rd_data_o     = rd_data_q;
  assign period_tick_o = wrap;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: table of duty/prescale configurations measured
// per period, plus hand sequences for double-buffering, enable toggling and async reset.
module tb_led_pwm_bank;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  pwm_out;
  logic        period_tick;

  int tests = 0;
  int fails = 0;

  int m_len;
  int m_low [4];

  typedef struct {
    logic [3:0][8:0]  duty;
    int               prescale;
    int               nper;
    int               exp_len;
    logic [3:0][10:0] exp_low;
  } vec_t;

  vec_t vecs [4];

  led_pwm_bank dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .pwm_out_o    (pwm_out),
    .period_tick_o(period_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
    rd_addr = addr;
    @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  task automatic wait_tick(input int limit, input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (period_tick) break;
      if (n >= limit) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s: no period_tick within %0d cycles", name, limit);
        break;
      end
    end
  endtask

  // Measures from just after one period_tick through the next one; optional writes to duty0.
  task automatic measure(input int mid_at, input logic [31:0] mid_data,
                         input bit tick_wr, input logic [31:0] tick_data);
    m_len = 0;
    for (int c = 0; c < 4; c++) m_low[c] = 0;
    while (1) begin
      @(negedge clk);
      wr_en = 1'b0;
      m_len++;
      for (int c = 0; c < 4; c++) if (!pwm_out[c]) m_low[c]++;
      if (m_len == mid_at) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = mid_data;
      end
      if (period_tick) begin
        if (tick_wr) begin
          wr_en = 1'b1; wr_addr = 4'd0; wr_data = tick_data;
        end
        break;
      end
      if (m_len > 5000) break;
    end
  endtask

  function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                              input int ps, input int nper, input int len,
                              input int l0, input int l1, input int l2, input int l3);
    vec_t v;
    v.duty[0] = 9'(d0); v.duty[1] = 9'(d1); v.duty[2] = 9'(d2); v.duty[3] = 9'(d3);
    v.prescale = ps;
    v.nper     = nper;
    v.exp_len  = len;
    v.exp_low[0] = 11'(l0); v.exp_low[1] = 11'(l1);
    v.exp_low[2] = 11'(l2); v.exp_low[3] = 11'(l3);
    return v;
  endfunction

  initial begin
    int bad;
    int n;
    vecs[0] = mk( 64, 0,   0,   0, 0, 2,  256,  64, 0,   0,    0);
    vecs[1] = mk( 64, 0, 256,   0, 0, 3,  256,  64, 0, 256,    0);
    vecs[2] = mk(128, 0,   0, 300, 3, 1, 1024, 512, 0,   0, 1024);
    vecs[3] = mk(255, 1,  17, 511, 1, 1,  512, 510, 2,  34,  512);

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset pwm_out", 32'(pwm_out), 32'hF);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset period_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm_out !== 4'hF || period_tick !== 1'b0) bad++;
    end
    chk("idle after reset, bad cycles", 32'(bad), 32'd0);

    // Read in the same cycle as a write returns the old value; unmapped addresses ignored.
    rd_addr = 4'd0;
    wr(4'd0, 32'd77);
    chk("read during write (old)", rd_data, 32'd0);
    @(negedge clk);
    chk("read after write", rd_data, 32'd77);
    wr(4'd9, 32'hFFFF);
    wr(4'd5, 32'hFFFF);
    rd(4'd9, 32'd0, "unmapped read addr9");
    rd(4'd5, 32'd0, "unmapped read addr5");

    for (int v = 0; v < 4; v++) begin
      wr(4'd4, 32'd0);
      for (int c = 0; c < 4; c++) wr(4'(c), 32'(vecs[v].duty[c]));
      rd(4'd0, 32'(vecs[v].duty[0]), $sformatf("v%0d duty0 readback", v));
      wr(4'd4, 32'((vecs[v].prescale << 1) | 1));
      rd(4'd4, 32'((vecs[v].prescale << 1) | 1), $sformatf("v%0d ctrl readback", v));
      wait_tick(3000, $sformatf("v%0d first tick", v));
      for (int p = 0; p < vecs[v].nper; p++) begin
        measure(-1, 32'd0, 1'b0, 32'd0);
        chk($sformatf("v%0d p%0d period len", v, p), 32'(m_len), 32'(vecs[v].exp_len));
        for (int c = 0; c < 4; c++)
          chk($sformatf("v%0d p%0d ch%0d on cycles", v, p, c), 32'(m_low[c]),
              32'(vecs[v].exp_low[c]));
      end
    end

    // Double buffer: 200 written mid-period, 10 written on the wrap cycle.
    wr(4'd4, 32'd0);
    wr(4'd0, 32'd50);
    for (int c = 1; c < 4; c++) wr(4'(c), 32'd0);
    wr(4'd4, 32'd1);
    wait_tick(1000, "dbuf first tick");
    measure(100, 32'd200, 1'b1, 32'd10);
    chk("dbuf period A (old duty 50)", 32'(m_low[0]), 32'd50);
    measure(-1, 32'd0, 1'b0, 32'd0);
    chk("dbuf period B (duty 200)", 32'(m_low[0]), 32'd200);
    measure(-1, 32'd0, 1'b0, 32'd0);
    chk("dbuf period C (duty 10)", 32'(m_low[0]), 32'd10);
    rd(4'd0, 32'd10, "dbuf duty0 readback");

    // Enable off mid-period, then back on.
    wait_tick(1000, "en tick");
    repeat (5) @(negedge clk);
    chk("running pin0 low", 32'(pwm_out[0]), 32'd0);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'd0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (pwm_out !== 4'hF || period_tick !== 1'b0) bad++;
    end
    chk("disabled, bad cycles", 32'(bad), 32'd0);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'd1;
    n = 0;
    while (1) begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
      if (period_tick || n >= 1000) break;
    end
    chk("re-enable to first tick", 32'(n), 32'd256);

    // Asynchronous reset mid-period.
    repeat (5) @(negedge clk);
    chk("pre-reset pin0 low", 32'(pwm_out[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset pwm_out", 32'(pwm_out), 32'hF);
    chk("async reset period_tick", 32'(period_tick), 32'd0);
    rd_addr = 4'd4;
    @(negedge clk);
    chk("async reset rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    rd(4'd0, 32'd0, "post-reset duty0");
    rd(4'd4, 32'd0, "post-reset ctrl");
    chk("post-reset pwm_out", 32'(pwm_out), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
